// File: rtl/riscv_pkg.sv
// Shared types for the instruction prefetch buffer: FSM state encoding,
// the FIFO entry layout and the word-alignment helper.
package riscv_pkg;

  typedef enum logic {
    PF_IDLE = 1'b0,
    PF_RUN  = 1'b1
  } prefetch_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } prefetch_entry_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Response FIFO for the prefetch buffer. The head entry is read straight
// out of the storage registers, so a pushed entry is visible one cycle
// after the push. Flush empties the FIFO in one cycle; push and pop on a
// full FIFO in the same cycle is accepted.
module prefetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         entry_t = prefetch_entry_t,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Next pointer/count values; flush overrides any push or pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + PTR_W'(1);
    if (pop_ok)  rd_d = rd_q + PTR_W'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_W'(1);
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok && !flush_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: sequential word fetches on the instr_* bus
// with up to MAX_OUTSTANDING requests in flight, responses buffered in a
// DEPTH-entry FIFO. A redirect flushes the FIFO and marks every response
// still owed by the bus (including a held, not yet granted request) as
// stale so it is dropped on arrival.
// Optional build macro: PREFETCH_STAT_EN adds stat_stall_cnt, a saturating
// count of RUN cycles where the consumer is ready but the FIFO is empty.
module instr_prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_enable,
  input  logic [31:0] boot_addr,
  input  logic        set_pc_valid,
  input  logic [31:0] set_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic [31:0] instr_rdata,
  input  logic        instr_err,
  input  logic        instr_valid
`ifdef PREFETCH_STAT_EN
  ,
  output logic [31:0] stat_stall_cnt
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  prefetch_state_e state_q, state_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   discard_q, discard_d;
  logic            stale_q, stale_d;
  logic [31:0]     aq_mem_q [MAX_OUTSTANDING];
  logic [AW-1:0]   aq_wr_q, aq_rd_q;

  prefetch_entry_t push_data;
  prefetch_entry_t head;
  logic [CW-1:0]   fifo_cnt, cnt_d;
  logic            fifo_full, fifo_empty;
  logic            gnt_fire, push, pop, can_issue;
  logic [31:0]     occ_d;

  assign instr_req  = req_q;
  assign instr_addr = addr_q;
  assign out_valid  = !fifo_empty;
  assign out_rdata  = head.rdata;
  assign out_addr   = head.addr;
  assign out_err    = head.err;

  assign gnt_fire = req_q && instr_gnt;
  // Responses are dropped while stale ones are owed, and in the redirect
  // cycle itself (that response necessarily predates the redirect).
  assign push = instr_valid && (discard_q == '0) && !set_pc_valid && (!fifo_full || pop);
  assign pop  = out_valid && out_ready && !set_pc_valid;

  assign push_data.rdata = instr_rdata;
  assign push_data.addr  = aq_mem_q[aq_rd_q];
  assign push_data.err   = instr_err;

  prefetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (prefetch_entry_t),
    .CNT_W   (CW)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (set_pc_valid),
    .head_o      (head),
    .count_o     (fifo_cnt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Next-state for FSM, fetch address, bookkeeping counters and the bus request.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    req_d        = req_q;
    addr_d       = addr_q;

    outst_d = outst_q;
    if (gnt_fire && !instr_valid)      outst_d = outst_q + OW'(1);
    else if (!gnt_fire && instr_valid) outst_d = outst_q - OW'(1);

    discard_d = discard_q;
    if (instr_valid && (discard_q != '0)) discard_d = discard_d - OW'(1);
    if (gnt_fire && stale_q)              discard_d = discard_d + OW'(1);
    stale_d = stale_q && !gnt_fire;
    if (set_pc_valid) begin
      // Everything in flight after this cycle predates the redirect; a held
      // request is counted once it is granted.
      discard_d = outst_d;
      stale_d   = req_q && !instr_gnt;
    end

    cnt_d = fifo_cnt;
    if (push && !pop)      cnt_d = fifo_cnt + CW'(1);
    else if (!push && pop) cnt_d = fifo_cnt - CW'(1);
    if (set_pc_valid) cnt_d = '0;

    unique case (state_q)
      PF_IDLE: begin
        fetch_addr_d = word_align(boot_addr);
        if (fetch_enable) state_d = PF_RUN;
      end
      PF_RUN: begin
        // A stale grant carries the old address, so it must not advance
        // the post-redirect fetch pointer.
        if (gnt_fire && !stale_q) fetch_addr_d = fetch_addr_q + 32'd4;
        if (set_pc_valid)         fetch_addr_d = word_align(set_pc);
        if (!fetch_enable && (outst_q == '0) && !req_q) state_d = PF_IDLE;
      end
      default: state_d = PF_IDLE;
    endcase

    // Reserve FIFO room for every request that can still return.
    occ_d     = 32'(cnt_d) + 32'(outst_d);
    can_issue = (state_d == PF_RUN) && fetch_enable &&
                (32'(outst_d) < MAX_OUTSTANDING) && (occ_d < DEPTH);

    if (!(req_q && !instr_gnt)) begin
      req_d = can_issue;
      if (can_issue) addr_d = fetch_addr_d;
    end
  end

  // FSM state, bus request and in-flight bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PF_IDLE;
      fetch_addr_q <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
      stale_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      stale_q      <= stale_d;
    end
  end

  // Address ring: one slot per granted request, consumed in response order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) aq_mem_q[i] <= '0;
      aq_wr_q <= '0;
      aq_rd_q <= '0;
    end else begin
      if (gnt_fire) begin
        aq_mem_q[aq_wr_q] <= addr_q;
        aq_wr_q <= (aq_wr_q == AW'(MAX_OUTSTANDING - 1)) ? '0 : aq_wr_q + AW'(1);
      end
      if (instr_valid) begin
        aq_rd_q <= (aq_rd_q == AW'(MAX_OUTSTANDING - 1)) ? '0 : aq_rd_q + AW'(1);
      end
    end
  end

`ifdef PREFETCH_STAT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles the consumer waits on an empty buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if ((state_q == PF_RUN) && out_ready && !out_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer. A small bus responder answers
// each granted request with rdata = ~addr (err when addr == err_at), one
// response per cycle, unless responses are held back.
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_enable;
  logic [31:0] boot_addr;
  logic        set_pc_valid;
  logic [31:0] set_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [31:0] out_addr;
  logic        out_err;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        instr_valid;
`ifdef PREFETCH_STAT_EN
  logic [31:0] stat_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic        resp_hold;
  logic [31:0] err_at;
  logic        snap_hit;
  logic [31:0] snap_addr;
  logic [31:0] rq_addr[$];
  logic [31:0] glog[$];
  logic [31:0] mon_addr[$];
  logic [31:0] mon_data[$];
  logic [31:0] mon_err[$];

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fetch_enable (fetch_enable),
    .boot_addr    (boot_addr),
    .set_pc_valid (set_pc_valid),
    .set_pc       (set_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rdata    (out_rdata),
    .out_addr     (out_addr),
    .out_err      (out_err),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_gnt    (instr_gnt),
    .instr_rdata  (instr_rdata),
    .instr_err    (instr_err),
    .instr_valid  (instr_valid)
`ifdef PREFETCH_STAT_EN
    ,
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  // Snapshot the handshake mid-cycle, away from the edge.
  always @(negedge clk) begin
    snap_hit  = instr_req && instr_gnt;
    snap_addr = instr_addr;
  end

  // Bus responder: record grants, return responses in order.
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      rq_addr.delete();
      instr_valid = 1'b0;
      instr_rdata = '0;
      instr_err   = 1'b0;
    end else begin
      if (snap_hit) begin
        rq_addr.push_back(snap_addr);
        glog.push_back(snap_addr);
      end
      if (!resp_hold && (rq_addr.size() > 0)) begin
        logic [31:0] a;
        a = rq_addr.pop_front();
        instr_valid = 1'b1;
        instr_rdata = ~a;
        instr_err   = (a == err_at);
      end else begin
        instr_valid = 1'b0;
        instr_rdata = '0;
        instr_err   = 1'b0;
      end
    end
  end

  // Consumer monitor: log every accepted pop.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready && !set_pc_valid) begin
      mon_addr.push_back(out_addr);
      mon_data.push_back(out_rdata);
      mon_err.push_back({31'd0, out_err});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    fetch_enable = 1'b0;
    boot_addr    = '0;
    set_pc_valid = 1'b0;
    set_pc       = '0;
    out_ready    = 1'b0;
    instr_gnt    = 1'b0;
    resp_hold    = 1'b0;
    err_at       = 32'h0000_0001;
    tick(2);
    mon_addr.delete();
    mon_data.delete();
    mon_err.delete();
    glog.delete();
    reset_n = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int k = 0;
    while ((mon_addr.size() < n) && (k < budget)) begin
      tick(1);
      k++;
    end
    if (mon_addr.size() < n) check_eq({tag, "_pop_timeout"}, 32'(mon_addr.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    fetch_enable = 1'b0;
    boot_addr    = 32'h0000_0040;
    set_pc_valid = 1'b0;
    set_pc       = '0;
    out_ready    = 1'b1;
    instr_gnt    = 1'b1;
    resp_hold    = 1'b0;
    err_at       = 32'h0000_0001;
    #12;
    check_eq("rst_req",   32'(instr_req), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_iaddr", instr_addr, 32'd0);
    check_eq("rst_rdata", out_rdata, 32'd0);
    check_eq("rst_oaddr", out_addr, 32'd0);
    check_eq("rst_err",   32'(out_err), 32'd0);

    // 1: sequential fetch from boot address
    do_reset();
    boot_addr = 32'h0000_0080; instr_gnt = 1'b1; out_ready = 1'b1; fetch_enable = 1'b1;
    wait_pops(3, 40, "t1");
    check_eq("t1_addr0", qget(mon_addr, 0), 32'h0000_0080);
    check_eq("t1_addr1", qget(mon_addr, 1), 32'h0000_0084);
    check_eq("t1_addr2", qget(mon_addr, 2), 32'h0000_0088);
    check_eq("t1_data0", qget(mon_data, 0), 32'hFFFF_FF7F);
    check_eq("t1_data2", qget(mon_data, 2), 32'hFFFF_FF77);

    // 2: back-pressure fills the FIFO, one pop frees exactly one request
    do_reset();
    boot_addr = 32'h0000_0080; instr_gnt = 1'b1; out_ready = 1'b0; fetch_enable = 1'b1;
    tick(20);
    check_eq("t2_req_full",   32'(instr_req), 32'd0);
    check_eq("t2_valid",      32'(out_valid), 32'd1);
    check_eq("t2_head",       out_addr, 32'h0000_0080);
    check_eq("t2_grants",     32'(glog.size()), 32'd4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(10);
    check_eq("t2_grants_pop", 32'(glog.size()), 32'd5);
    check_eq("t2_new_addr",   qget(glog, 4), 32'h0000_0090);
    check_eq("t2_req_again",  32'(instr_req), 32'd0);
    check_eq("t2_head_pop",   out_addr, 32'h0000_0084);
    check_eq("t2_pops",       32'(mon_addr.size()), 32'd1);

    // 3: two in flight, redirect discards both
    do_reset();
    boot_addr = 32'h0000_0080; instr_gnt = 1'b1; out_ready = 1'b1; resp_hold = 1'b1;
    fetch_enable = 1'b1;
    tick(8);
    check_eq("t3_req_max", 32'(instr_req), 32'd0);
    check_eq("t3_grants",  32'(glog.size()), 32'd2);
    set_pc = 32'h0000_0203; set_pc_valid = 1'b1;
    tick(1);
    set_pc_valid = 1'b0; resp_hold = 1'b0;
    wait_pops(2, 40, "t3");
    check_eq("t3_addr0", qget(mon_addr, 0), 32'h0000_0200);
    check_eq("t3_addr1", qget(mon_addr, 1), 32'h0000_0204);
    check_eq("t3_data0", qget(mon_data, 0), 32'hFFFF_FDFF);
    check_eq("t3_gnt2",  qget(glog, 2), 32'h0000_0200);

    // 4: redirect while a request waits for grant
    do_reset();
    boot_addr = 32'h0000_0080; instr_gnt = 1'b0; out_ready = 1'b1; fetch_enable = 1'b1;
    tick(2);
    set_pc = 32'h0000_0300; set_pc_valid = 1'b1;
    tick(1);
    set_pc_valid = 1'b0;
    tick(2);
    check_eq("t4_req_held",  32'(instr_req), 32'd1);
    check_eq("t4_addr_held", instr_addr, 32'h0000_0080);
    instr_gnt = 1'b1;
    wait_pops(1, 40, "t4");
    check_eq("t4_addr0", qget(mon_addr, 0), 32'h0000_0300);
    check_eq("t4_gnt0",  qget(glog, 0), 32'h0000_0080);
    check_eq("t4_gnt1",  qget(glog, 1), 32'h0000_0300);

    // 5: error flag on second response only
    do_reset();
    boot_addr = 32'h0000_0080; instr_gnt = 1'b1; out_ready = 1'b1; err_at = 32'h0000_0084;
    fetch_enable = 1'b1;
    wait_pops(3, 40, "t5");
    check_eq("t5_err0",  qget(mon_err, 0), 32'd0);
    check_eq("t5_err1",  qget(mon_err, 1), 32'd1);
    check_eq("t5_err2",  qget(mon_err, 2), 32'd0);
    check_eq("t5_addr2", qget(mon_addr, 2), 32'h0000_0088);

    // 6: address wrap, unaligned boot address
    do_reset();
    boot_addr = 32'hFFFF_FFFB; instr_gnt = 1'b1; out_ready = 1'b1; fetch_enable = 1'b1;
    wait_pops(3, 40, "t6");
    check_eq("t6_gnt0",  qget(glog, 0), 32'hFFFF_FFF8);
    check_eq("t6_gnt1",  qget(glog, 1), 32'hFFFF_FFFC);
    check_eq("t6_gnt2",  qget(glog, 2), 32'h0000_0000);
    check_eq("t6_addr2", qget(mon_addr, 2), 32'h0000_0000);
    check_eq("t6_data2", qget(mon_data, 2), 32'hFFFF_FFFF);

`ifdef PREFETCH_STAT_EN
    do_reset();
    check_eq("stat_rst", stat_stall_cnt, 32'd0);
    boot_addr = 32'h0000_0100; instr_gnt = 1'b0; out_ready = 1'b0; fetch_enable = 1'b1;
    tick(1);
    out_ready = 1'b1;
    tick(7);
    check_eq("stat_cnt", stat_stall_cnt, 32'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
